// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and helpers for the matmul datapath.
//   DEF_*       default engine dimensions and operand width
//   elem_width  width of a signed result element for a given operand
//               width and inner dimension
//   sat_elem    clamp a sign-extended value to a signed w-bit range;
//               shared by the result streamer and later narrowing stages
//   stream_state_e  state encoding of the result streamer
package matmul_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_M          = 32;
    localparam int unsigned DEF_N          = 32;
    localparam int unsigned DEF_Q          = 32;

    function automatic int unsigned elem_width(input int unsigned dw, input int unsigned m);
        return 2 * dw + int'($clog2(m));
    endfunction

    // x must already be sign-extended to 64 bits; w is the target width.
    function automatic logic signed [63:0] sat_elem(input logic signed [63:0] x,
                                                    input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FIN    = 2'd2
    } stream_state_e;

endpackage

// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer: snapshots a finished N x Q result matrix on
// start and drains it row-major onto a valid/ready element stream.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   start        one-cycle request; honoured only when idle
//   mat_in       result matrix from the engine, captured on accepted start
//   busy         high while the stream is being drained
//   m_valid      element valid
//   m_ready      downstream accept
//   m_data       current element (ELEM_W signed)
//   m_row_last   current element is the last column of its row
//   m_last       current element is the final element of the matrix
//   done         one-cycle pulse after the final handshake
//   sat_seen     sticky: a clamped element was accepted since the last start
//
// Build option: define MATMUL_STREAM_SAT_EN to clamp m_data to the signed
// 2*DATA_WIDTH range (sign-extended back to ELEM_W) and drive sat_seen.
// Without it m_data is the raw element and sat_seen is tied low.
module matmul_result_streamer
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned M          = DEF_M,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned Q          = DEF_Q,
    localparam int unsigned ELEM_W    = elem_width(DATA_WIDTH, M)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [ELEM_W-1:0] mat_in [N-1:0][Q-1:0],
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [ELEM_W-1:0] m_data,
    output logic                     m_row_last,
    output logic                     m_last,
    output logic                     done,
    output logic                     sat_seen
);

    typedef logic signed [ELEM_W-1:0] elem_t;

    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned COL_W = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(Q - 1);

    stream_state_e    state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    elem_t            buf_q [N-1:0][Q-1:0];

    logic  capture;
    logic  handshake;
    logic  at_row_end;
    logic  at_mat_end;
    elem_t raw_elem;
    elem_t elem_out;

    assign capture    = (state_q == ST_IDLE) && start;
    assign handshake  = (state_q == ST_STREAM) && m_ready;
    assign at_row_end = (col_q == COL_LAST);
    assign at_mat_end = at_row_end && (row_q == ROW_LAST);

    // Snapshot buffer carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= mat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_STREAM: begin
                if (m_ready) begin
                    if (at_row_end) begin
                        col_d = '0;
                        if (at_mat_end) begin
                            state_d = ST_FIN;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Element is a mux off the frozen buffer, so it is stable while stalled.
    assign raw_elem = buf_q[row_q][col_q];

`ifdef MATMUL_STREAM_SAT_EN
    logic signed [63:0] wide_elem;
    logic signed [63:0] clamped_elem;
    logic               elem_clamped;
    logic               sat_seen_q;

    always_comb begin
        wide_elem    = 64'(raw_elem);
        clamped_elem = sat_elem(wide_elem, 2 * DATA_WIDTH);
        elem_out     = ELEM_W'(clamped_elem);
        elem_clamped = (clamped_elem != wide_elem);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_seen_q <= 1'b0;
        end else if (capture) begin
            sat_seen_q <= 1'b0;
        end else if (handshake && elem_clamped) begin
            sat_seen_q <= 1'b1;
        end
    end

    assign sat_seen = sat_seen_q;
`else
    assign elem_out = raw_elem;
    assign sat_seen = 1'b0;
`endif

    assign m_valid    = (state_q == ST_STREAM);
    assign busy       = (state_q == ST_STREAM);
    assign done       = (state_q == ST_FIN);
    assign m_data     = m_valid ? elem_out : '0;
    assign m_row_last = m_valid && at_row_end;
    assign m_last     = m_valid && at_mat_end;

endmodule

// File: tb/tb_matmul_result_streamer.sv
module tb_matmul_result_streamer;

    localparam int unsigned DW = 8;
    localparam int unsigned MM = 4;
    localparam int unsigned NN = 2;
    localparam int unsigned QQ = 3;
    localparam int unsigned EW = 18;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic signed [EW-1:0] mat_in [NN-1:0][QQ-1:0];
    logic                 busy;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [EW-1:0] m_data;
    logic                 m_row_last;
    logic                 m_last;
    logic                 done;
    logic                 sat_seen;

    int n_cmp;
    int n_bad;

    matmul_result_streamer #(
        .DATA_WIDTH(DW),
        .M         (MM),
        .N         (NN),
        .Q         (QQ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mat_in    (mat_in),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row_last(m_row_last),
        .m_last    (m_last),
        .done      (done),
        .sat_seen  (sat_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic                 do_start;
        logic                 ready;
        logic                 valid;
        logic signed [EW-1:0] data;
        logic                 row_last;
        logic                 last;
        logic                 done;
        logic                 busy;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_data(input string name, input logic signed [EW-1:0] exp);
        check(name, {46'd0, m_data}, {46'd0, exp});
    endtask

    task automatic load_seq();
        for (int r = 0; r < int'(NN); r++)
            for (int c = 0; c < int'(QQ); c++)
                mat_in[r][c] = EW'(r * int'(QQ) + c + 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic add(input logic s, input logic rd, input logic v, input int d,
                       input logic rl, input logic l, input logic dn, input logic b);
        vec_t t;
        t.do_start = s;
        t.ready    = rd;
        t.valid    = v;
        t.data     = EW'(d);
        t.row_last = rl;
        t.last     = l;
        t.done     = dn;
        t.busy     = b;
        vecs.push_back(t);
    endtask

    initial begin
        int hs;
        int dones;
        logic signed [EW-1:0] exp3 [6];
        logic signed [EW-1:0] e;

        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int r = 0; r < int'(NN); r++)
            for (int c = 0; c < int'(QQ); c++)
                mat_in[r][c] = '0;

        // Scenario 1: m_ready held high
        add(1, 1, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 2, 0, 0, 0, 1);
        add(0, 1, 1, 3, 1, 0, 0, 1);
        add(0, 1, 1, 4, 0, 0, 0, 1);
        add(0, 1, 1, 5, 0, 0, 0, 1);
        add(0, 1, 1, 6, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Scenario 2: m_ready 1,0,0,1,... with stalls holding the element
        add(1, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 2, 0, 0, 0, 1);
        add(0, 0, 1, 2, 0, 0, 0, 1);
        add(0, 1, 1, 2, 0, 0, 0, 1);
        add(0, 1, 1, 3, 1, 0, 0, 1);
        add(0, 0, 1, 4, 0, 0, 0, 1);
        add(0, 0, 1, 4, 0, 0, 0, 1);
        add(0, 1, 1, 4, 0, 0, 0, 1);
        add(0, 1, 1, 5, 0, 0, 0, 1);
        add(0, 0, 1, 6, 1, 1, 0, 1);
        add(0, 0, 1, 6, 1, 1, 0, 1);
        add(0, 1, 1, 6, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check_data("rst_data", '0);
        check("rst_row_last", 64'(m_row_last), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sat", 64'(sat_seen), 64'd0);
        reset = 1'b0;
        tick();

        // Scenarios 1 and 2 from the table
        load_seq();
        hs = 0;
        foreach (vecs[i]) begin
            if (vecs[i].do_start) pulse_start();
            m_ready = vecs[i].ready;
            check($sformatf("v%0d_valid", i), 64'(m_valid), 64'(vecs[i].valid));
            check_data($sformatf("v%0d_data", i), vecs[i].data);
            check($sformatf("v%0d_row_last", i), 64'(m_row_last), 64'(vecs[i].row_last));
            check($sformatf("v%0d_last", i), 64'(m_last), 64'(vecs[i].last));
            check($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].done));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
            if (m_valid && m_ready) hs++;
            tick();
        end
        check("handshakes_s1_s2", 64'(hs), 64'd12);

        // Scenario 3: recapture attempt mid-stream is ignored
        exp3[0] = -18'sd5;  exp3[1] = 18'sd0;    exp3[2] = 18'sd7;
        exp3[3] = 18'sd100; exp3[4] = -18'sd200; exp3[5] = 18'sd3;
        for (int k = 0; k < 6; k++) mat_in[k / 3][k % 3] = exp3[k];
        m_ready = 1'b0;
        pulse_start();
        for (int r = 0; r < int'(NN); r++)
            for (int c = 0; c < int'(QQ); c++)
                mat_in[r][c] = 18'sd99;
        m_ready = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            check_data($sformatf("s3_data%0d", k), exp3[k]);
            if (done) dones++;
            start = (k == 2);
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            tick();
        end
        check("s3_done_count", 64'(dones), 64'd1);
        check("s3_idle_valid", 64'(m_valid), 64'd0);

        // Scenario 4: reset after the third handshake
        load_seq();
        pulse_start();
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        check_data("s4_pre_reset_data", 18'sd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s4_valid", 64'(m_valid), 64'd0);
        check("s4_busy", 64'(busy), 64'd0);
        check_data("s4_data", '0);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            tick();
        end
        check("s4_no_done", 64'(dones), 64'd0);
        m_ready = 1'b0;
        pulse_start();
        check("s4_restart_valid", 64'(m_valid), 64'd1);
        check_data("s4_restart_data", 18'sd1);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("s4_final_idle", 64'(busy), 64'd0);

        // Scenario 5: saturation behaviour
        mat_in[0][0] = 18'sd40000;
        mat_in[0][1] = -18'sd40000;
        mat_in[0][2] = 18'sd5;
        mat_in[1][0] = 18'sd6;
        mat_in[1][1] = 18'sd7;
        mat_in[1][2] = 18'sd8;
        m_ready = 1'b0;
        pulse_start();
        check("s5_sat_before", 64'(sat_seen), 64'd0);
`ifdef MATMUL_STREAM_SAT_EN
        e = 18'sd32767;
`else
        e = 18'sd40000;
`endif
        check_data("s5_data0", e);
        m_ready = 1'b1;
        tick();
`ifdef MATMUL_STREAM_SAT_EN
        check("s5_sat_after_hs", 64'(sat_seen), 64'd1);
        e = -18'sd32768;
`else
        check("s5_sat_after_hs", 64'(sat_seen), 64'd0);
        e = -18'sd40000;
`endif
        check_data("s5_data1", e);
        tick();
        check_data("s5_data2", 18'sd5);
        for (int k = 0; k < 6; k++) tick();
`ifdef MATMUL_STREAM_SAT_EN
        check("s5_sat_sticky", 64'(sat_seen), 64'd1);
`else
        check("s5_sat_sticky", 64'(sat_seen), 64'd0);
`endif
        m_ready = 1'b0;
        pulse_start();
        check("s5_sat_cleared_on_start", 64'(sat_seen), 64'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
